// File: rtl/rle_stream_sched_pkg.sv
// Shared types and widths for the RLE stream scheduler slice.
package rle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RST_ENC,
    ACTIVE,
    RELEASE
  } sched_state_t;

  localparam int unsigned RLE_OUT_W = 24;
  localparam int unsigned RLE_IN_W  = 8;

endpackage

// File: rtl/rle_stream_sched_if.sv
// Encoder-side handshake bus between the scheduler (master) and the shared RLE encoder (slave).
interface rle_stream_sched_if;
  import rle_pkg::*;

  logic                 enc_rst;
  logic                 enc_recv_ready;
  logic [RLE_IN_W-1:0]  enc_in_data;
  logic                 enc_eos;
  logic                 enc_send_ready;
  logic                 enc_rd_req;
  logic                 enc_wr_req;
  logic [RLE_OUT_W-1:0] enc_out_data;

  modport master (
    output enc_rst, enc_recv_ready, enc_in_data, enc_eos, enc_send_ready,
    input  enc_rd_req, enc_wr_req, enc_out_data
  );

  modport slave (
    input  enc_rst, enc_recv_ready, enc_in_data, enc_eos, enc_send_ready,
    output enc_rd_req, enc_wr_req, enc_out_data
  );

endinterface

// File: rtl/rle_stream_sched_rr_arbiter.sv
// Combinational rotating-priority picker: first requester strictly after i_ptr wins.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_valid
);

  logic [PW-1:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    // Offset 1..N from the pointer, so the last owner has lowest priority.
    for (int unsigned i = 1; i <= N; i++) begin
      w_idx = PW'((32'(i_ptr) + i) % N);
      if (!o_valid && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rle_stream_sched.sv
// Time-shares one RLE encoder between N_CH byte streams, granting whole streams round-robin.
module rle_stream_sched
  import rle_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned ENC_RST_CYC = 2,
  parameter int unsigned LEN_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_recv_ready,
  input  logic [RLE_IN_W*N_CH-1:0] ch_in_data,
  input  logic [N_CH-1:0]          ch_eos,
  output logic [N_CH-1:0]          ch_rd_req,
  input  logic [N_CH-1:0]          ch_send_ready,
  output logic [N_CH-1:0]          ch_wr_req,
  output logic [RLE_OUT_W-1:0]     ch_out_data,
  rle_stream_sched_if.master       enc,
  output logic [N_CH-1:0]          grant,
  output logic                     stream_done,
  output logic [LEN_W-1:0]         stream_len
);

  localparam int unsigned PW = $clog2(N_CH);
  localparam int unsigned CW = $clog2(ENC_RST_CYC);

  sched_state_t  r_state, w_state_nxt;
  logic [N_CH-1:0]  r_grant;
  logic [PW-1:0]    r_gidx, r_ptr, w_arb_idx;
  logic             r_dirty;
  logic [LEN_W-1:0] r_cnt, r_len, w_cnt_nxt;
  logic [CW-1:0]    r_rcnt;
  logic [N_CH-1:0]  w_arb_gnt;
  logic             w_arb_valid, w_active, w_g_eos, w_g_ready, w_release;

  rr_arbiter #(.N(N_CH), .PW(PW)) u_arb (
    .i_req   (ch_recv_ready),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_valid (w_arb_valid)
  );

  always_comb begin
    w_arb_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_arb_gnt[i]) w_arb_idx = PW'(i);
    end
  end

  // Gating with rst keeps the encoder in reset and the demux quiet while rst is low.
  assign w_active  = (r_state == ACTIVE) && rst;
  assign w_g_eos   = ch_eos[r_gidx];
  assign w_g_ready = ch_recv_ready[r_gidx];
  assign w_cnt_nxt = (w_active && enc.enc_wr_req && (r_cnt != '1)) ? r_cnt + 1'b1 : r_cnt;
  assign w_release = w_active && w_g_eos &&
                     (enc.enc_wr_req || (!w_g_ready && !r_dirty));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt        = r_state;
    enc.enc_rst        = !w_active;
    enc.enc_recv_ready = w_active && w_g_ready;
    enc.enc_eos        = w_active && w_g_eos;
    enc.enc_send_ready = w_active && ch_send_ready[r_gidx];
    enc.enc_in_data    = ch_in_data[RLE_IN_W*r_gidx +: RLE_IN_W];
    ch_rd_req          = (w_active && enc.enc_rd_req) ? r_grant : '0;
    ch_wr_req          = (w_active && enc.enc_wr_req) ? r_grant : '0;
    ch_out_data        = w_active ? enc.enc_out_data : '0;
    unique case (r_state)
      IDLE:    if (w_arb_valid) w_state_nxt = RST_ENC;
      RST_ENC: if (r_rcnt == CW'(ENC_RST_CYC - 1)) w_state_nxt = ACTIVE;
      ACTIVE:  if (w_release) w_state_nxt = RELEASE;
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= PW'(N_CH - 1);
      r_dirty <= 1'b0;
      r_cnt   <= '0;
      r_rcnt  <= '0;
      r_len   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_rcnt <= '0;
          if (w_arb_valid) begin
            r_grant <= w_arb_gnt;
            r_gidx  <= w_arb_idx;
          end
        end
        RST_ENC: r_rcnt <= r_rcnt + 1'b1;
        ACTIVE: begin
          r_cnt <= w_cnt_nxt;
          if (enc.enc_rd_req)      r_dirty <= 1'b1;
          else if (enc.enc_wr_req) r_dirty <= 1'b0;
          if (w_release) r_len <= w_cnt_nxt;
        end
        RELEASE: begin
          r_ptr   <= r_gidx;
          r_grant <= '0;
          r_cnt   <= '0;
          r_dirty <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign grant       = r_grant;
  assign stream_done = (r_state == RELEASE) && rst;
  assign stream_len  = r_len;

endmodule

// File: tb/tb_rle_stream_sched.sv
// Directed bench for rle_stream_sched; the bench plays the encoder on the slave side of the bus.
module tb_rle_stream_sched;
  import rle_pkg::*;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned LEN_W = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       ch_recv_ready, ch_eos, ch_rd_req, ch_send_ready, ch_wr_req, grant;
  logic [8*N_CH-1:0]     ch_in_data;
  logic [RLE_OUT_W-1:0]  ch_out_data;
  logic                  stream_done;
  logic [LEN_W-1:0]      stream_len;
  int unsigned           n_pass = 0;
  int unsigned           n_total = 0;

  rle_stream_sched_if bus();

  rle_stream_sched #(.N_CH(N_CH), .ENC_RST_CYC(2), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_recv_ready (ch_recv_ready),
    .ch_in_data    (ch_in_data),
    .ch_eos        (ch_eos),
    .ch_rd_req     (ch_rd_req),
    .ch_send_ready (ch_send_ready),
    .ch_wr_req     (ch_wr_req),
    .ch_out_data   (ch_out_data),
    .enc           (bus.master),
    .grant         (grant),
    .stream_done   (stream_done),
    .stream_len    (stream_len)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ch_recv_ready = '0; ch_eos = '0; ch_send_ready = '1; ch_in_data = '0;
    bus.enc_rd_req = 1'b1; bus.enc_wr_req = 1'b1; bus.enc_out_data = 24'h123456;
    step(); step();
    n_total++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else n_pass++;
    n_total++; if (bus.enc_rst !== 1'b1) $display("FAIL reset_enc_rst: got %b want 1", bus.enc_rst); else n_pass++;
    n_total++; if (stream_done !== 1'b0) $display("FAIL reset_done: got %b want 0", stream_done); else n_pass++;
    n_total++; if (stream_len !== 16'd0) $display("FAIL reset_len: got %0d want 0", stream_len); else n_pass++;
    n_total++; if (ch_rd_req !== 4'b0 || ch_wr_req !== 4'b0)
      $display("FAIL reset_req: got rd=%b wr=%b want 0000", ch_rd_req, ch_wr_req); else n_pass++;
    bus.enc_rd_req = 1'b0; bus.enc_wr_req = 1'b0; bus.enc_out_data = '0;
    rst = 1'b1;
  endtask

  task automatic test_single_stream();
    ch_in_data[7:0] = 8'h00; ch_recv_ready = 4'b0001;
    step();
    n_total++; if (grant !== 4'b0001) $display("FAIL t1_grant: got %b want 0001", grant); else n_pass++;
    n_total++; if (bus.enc_rst !== 1'b1 || bus.enc_recv_ready !== 1'b0)
      $display("FAIL t1_rstenc: got rst=%b rr=%b want 1/0", bus.enc_rst, bus.enc_recv_ready); else n_pass++;
    step();
    n_total++; if (bus.enc_rst !== 1'b1) $display("FAIL t1_rstlen: got %b want 1", bus.enc_rst); else n_pass++;
    step();
    n_total++; if (bus.enc_rst !== 1'b0 || bus.enc_recv_ready !== 1'b1 || bus.enc_in_data !== 8'h00)
      $display("FAIL t1_active: got rst=%b rr=%b d=%h want 0/1/00",
               bus.enc_rst, bus.enc_recv_ready, bus.enc_in_data); else n_pass++;
    bus.enc_rd_req = 1'b1; #1;
    n_total++; if (ch_rd_req !== 4'b0001) $display("FAIL t1_rd: got %b want 0001", ch_rd_req); else n_pass++;
    step(); ch_in_data[7:0] = 8'hFF; #1;
    n_total++; if (bus.enc_in_data !== 8'hFF) $display("FAIL t1_data: got %h want ff", bus.enc_in_data); else n_pass++;
    step(); bus.enc_rd_req = 1'b0; ch_recv_ready = 4'b0000;
    step(); bus.enc_wr_req = 1'b1; bus.enc_out_data = 24'h000008; #1;
    n_total++; if (ch_wr_req !== 4'b0001 || ch_out_data !== 24'h000008)
      $display("FAIL t1_wr0: got wr=%b d=%h want 0001/000008", ch_wr_req, ch_out_data); else n_pass++;
    step(); ch_eos = 4'b0001; bus.enc_out_data = 24'h800008; #1;
    n_total++; if (ch_out_data !== 24'h800008) $display("FAIL t1_wr1: got %h want 800008", ch_out_data); else n_pass++;
    step(); bus.enc_wr_req = 1'b0; ch_eos = 4'b0000; #1;
    n_total++; if (stream_done !== 1'b1 || stream_len !== 16'd2 || bus.enc_rst !== 1'b1)
      $display("FAIL t1_release: got done=%b len=%0d rst=%b want 1/2/1", stream_done, stream_len, bus.enc_rst); else n_pass++;
    step();
    n_total++; if (stream_done !== 1'b0 || grant !== 4'b0000 || stream_len !== 16'd2)
      $display("FAIL t1_idle: got done=%b g=%b len=%0d want 0/0000/2", stream_done, grant, stream_len); else n_pass++;
  endtask

  task automatic test_two_requesters();
    rst = 1'b0; step(); rst = 1'b1;
    ch_in_data = 32'h33_00_11_00; ch_recv_ready = 4'b1010;
    step();
    n_total++; if (grant !== 4'b0010) $display("FAIL t2_first: got %b want 0010", grant); else n_pass++;
    step(); step();
    n_total++; if (bus.enc_in_data !== 8'h11) $display("FAIL t2_data1: got %h want 11", bus.enc_in_data); else n_pass++;
    bus.enc_rd_req = 1'b1; #1;
    n_total++; if (ch_rd_req !== 4'b0010) $display("FAIL t2_rd_only_ch1: got %b want 0010", ch_rd_req); else n_pass++;
    step(); bus.enc_rd_req = 1'b0; bus.enc_wr_req = 1'b1; bus.enc_out_data = 24'h000008; ch_eos = 4'b0010;
    step(); bus.enc_wr_req = 1'b0; ch_eos = 4'b0000; ch_recv_ready = 4'b1000; #1;
    n_total++; if (stream_done !== 1'b1 || stream_len !== 16'd1)
      $display("FAIL t2_rel1: got done=%b len=%0d want 1/1", stream_done, stream_len); else n_pass++;
    step(); step();
    n_total++; if (grant !== 4'b1000) $display("FAIL t2_second: got %b want 1000", grant); else n_pass++;
    step(); step();
    n_total++; if (bus.enc_in_data !== 8'h33) $display("FAIL t2_data3: got %h want 33", bus.enc_in_data); else n_pass++;
    ch_recv_ready = 4'b0000; ch_eos = 4'b1000;
    step(); ch_eos = 4'b0000; #1;
    n_total++; if (stream_done !== 1'b1 || stream_len !== 16'd0)
      $display("FAIL t2_rel3: got done=%b len=%0d want 1/0", stream_done, stream_len); else n_pass++;
    step();
  endtask

  task automatic test_empty_tail();
    ch_in_data[23:16] = 8'h22; ch_recv_ready = 4'b0100;
    step();
    n_total++; if (grant !== 4'b0100) $display("FAIL t3_grant: got %b want 0100", grant); else n_pass++;
    step(); step();
    bus.enc_rd_req = 1'b1;
    step(); bus.enc_rd_req = 1'b0; ch_recv_ready = 4'b0000;
    step(); bus.enc_wr_req = 1'b1; bus.enc_out_data = 24'h000010;
    step(); bus.enc_wr_req = 1'b0; ch_eos = 4'b0100; #1;
    n_total++; if (ch_wr_req !== 4'b0000 || bus.enc_eos !== 1'b1)
      $display("FAIL t3_tail: got wr=%b eos=%b want 0000/1", ch_wr_req, bus.enc_eos); else n_pass++;
    step(); ch_eos = 4'b0000; #1;
    n_total++; if (stream_done !== 1'b1 || stream_len !== 16'd1)
      $display("FAIL t3_release: got done=%b len=%0d want 1/1", stream_done, stream_len); else n_pass++;
    step();
  endtask

  task automatic test_dirty_hold();
    ch_recv_ready = 4'b0100;
    step();
    n_total++; if (grant !== 4'b0100) $display("FAIL t3b_regrant: got %b want 0100", grant); else n_pass++;
    step(); step();
    bus.enc_rd_req = 1'b1;
    step(); bus.enc_rd_req = 1'b0; ch_recv_ready = 4'b0000; ch_eos = 4'b0100;
    step();
    n_total++; if (bus.enc_rst !== 1'b0 || stream_done !== 1'b0)
      $display("FAIL t3b_dirty_hold: got rst=%b done=%b want 0/0", bus.enc_rst, stream_done); else n_pass++;
    bus.enc_wr_req = 1'b1; bus.enc_out_data = 24'h800003;
    step(); bus.enc_wr_req = 1'b0; ch_eos = 4'b0000; #1;
    n_total++; if (stream_done !== 1'b1 || stream_len !== 16'd1)
      $display("FAIL t3b_release: got done=%b len=%0d want 1/1", stream_done, stream_len); else n_pass++;
    step();
  endtask

  task automatic test_backpressure();
    int unsigned bad;
    ch_in_data[7:0] = 8'h5A; ch_recv_ready = 4'b0011;
    step();
    n_total++; if (grant !== 4'b0001) $display("FAIL t4_grant0: got %b want 0001", grant); else n_pass++;
    step(); step();
    bus.enc_rd_req = 1'b1;
    step(); bus.enc_rd_req = 1'b0; ch_send_ready[0] = 1'b0; #1;
    n_total++; if (bus.enc_send_ready !== 1'b0) $display("FAIL t4_sr_low: got %b want 0", bus.enc_send_ready); else n_pass++;
    bad = 0;
    repeat (50) begin
      step();
      if (grant !== 4'b0001 || ch_rd_req !== 4'b0 || stream_done !== 1'b0 || bus.enc_rst !== 1'b0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL t4_hold: got %0d bad cycles want 0", bad); else n_pass++;
    ch_send_ready[0] = 1'b1; bus.enc_wr_req = 1'b1; bus.enc_out_data = 24'h000020;
    ch_eos = 4'b0001; ch_recv_ready[0] = 1'b0; #1;
    n_total++; if (bus.enc_send_ready !== 1'b1 || ch_out_data !== 24'h000020 || ch_wr_req !== 4'b0001)
      $display("FAIL t4_resume: got sr=%b d=%h wr=%b want 1/000020/0001",
               bus.enc_send_ready, ch_out_data, ch_wr_req); else n_pass++;
    step(); bus.enc_wr_req = 1'b0; ch_eos = 4'b0000; #1;
    n_total++; if (stream_done !== 1'b1 || stream_len !== 16'd1)
      $display("FAIL t4_release: got done=%b len=%0d want 1/1", stream_done, stream_len); else n_pass++;
    step(); step();
    n_total++; if (grant !== 4'b0010) $display("FAIL t4_then_ch1: got %b want 0010", grant); else n_pass++;
    step(); step();
    ch_recv_ready = 4'b0000; ch_eos = 4'b0010;
    step(); ch_eos = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_stream();
    int unsigned pulses;
    ch_recv_ready = 4'b0001;
    step(); step(); step();
    bus.enc_rd_req = 1'b1;
    step(); bus.enc_rd_req = 1'b0; rst = 1'b0; #1;
    n_total++; if (bus.enc_rst !== 1'b1) $display("FAIL t5_enc_rst_now: got %b want 1", bus.enc_rst); else n_pass++;
    pulses = 0;
    step(); if (stream_done !== 1'b0) pulses++;
    n_total++; if (grant !== 4'b0000 || bus.enc_rst !== 1'b1)
      $display("FAIL t5_after: got g=%b rst=%b want 0000/1", grant, bus.enc_rst); else n_pass++;
    step(); if (stream_done !== 1'b0) pulses++;
    rst = 1'b1; ch_recv_ready = 4'b0110;
    step(); if (stream_done !== 1'b0) pulses++;
    n_total++; if (pulses != 0) $display("FAIL t5_no_done: got %0d pulses want 0", pulses); else n_pass++;
    n_total++; if (grant !== 4'b0010) $display("FAIL t5_fresh_arb: got %b want 0010", grant); else n_pass++;
    n_total++; if (stream_len !== 16'd0) $display("FAIL t5_len_clr: got %0d want 0", stream_len); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [N_CH-1:0] exp_g;
    rst = 1'b0; ch_recv_ready = 4'b1111; ch_eos = '0;
    bus.enc_rd_req = 1'b0; bus.enc_wr_req = 1'b0;
    step(); rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      step();
      n_total++; if (grant !== exp_g) $display("FAIL t6_grant%0d: got %b want %b", k, grant, exp_g); else n_pass++;
      step(); step();
      bus.enc_wr_req = 1'b1; bus.enc_out_data = 24'h000001; ch_eos = exp_g;
      step(); bus.enc_wr_req = 1'b0; ch_eos = '0; #1;
      n_total++; if (stream_done !== 1'b1) $display("FAIL t6_done%0d: got %b want 1", k, stream_done); else n_pass++;
      step();
      n_total++; if (stream_done !== 1'b0) $display("FAIL t6_pulse%0d: got %b want 0", k, stream_done); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_two_requesters();
    test_empty_tail();
    test_dirty_hold();
    test_backpressure();
    test_reset_mid_stream();
    test_round_robin();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
